cla_seq_ctrl: RTL and testbench
===============================

CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, setting the adder slice width in bits.
REQ-002 The block SHALL have parameter W, default 4, setting the slice count; operand width is N*W.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1; reset SHALL be asynchronous and active-low.
REQ-005 Port in_valid, input, 1: operands and cin are valid.
REQ-006 Port in_ready, output, 1: block accepts a new operation.
REQ-007 Ports a and b, inputs, N*W each: the operands.
REQ-008 Port cin, input, 1: carry into bit 0.
REQ-009 Port out_valid, output, 1: sum and cout are valid.
REQ-010 Port out_ready, input, 1: consumer accepts the result.
REQ-011 Port sum, output, N*W: the result.
REQ-012 Port cout, output, 1: carry out of the MSB.
REQ-013 Port busy, output, 1: high in every state except IDLE.

Function
REQ-014 The block SHALL contain one N-bit carry-lookahead slice (generate/propagate per bit, lookahead carries) that is reused across W cycles.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE.
REQ-017 On an edge with in_valid and in_ready both high, the block SHALL latch a, b and cin, clear the slice index, and enter RUN.
REQ-018 In RUN, each cycle SHALL add slice idx (bits idx*N..idx*N+N-1) of the latched operands with the carry register, write the result into the same slice of sum, update the carry register, and increment idx.
REQ-019 After the edge that processes idx = W-1, the block SHALL enter DONE with out_valid=1 and cout equal to the final carry; out_valid is therefore first seen W cycles after the accepting edge.
REQ-020 In DONE, sum, cout and out_valid SHALL hold stable while out_ready=0.
REQ-021 On an edge in DONE with out_ready=1, the block SHALL return to IDLE with out_valid=0; sum and cout keep their last values.
REQ-022 in_valid outside IDLE SHALL be ignored and SHALL NOT corrupt the operation in progress.
REQ-023 Input changes after acceptance SHALL NOT affect the result.
REQ-024 out_ready outside DONE SHALL be ignored.
REQ-025 The block SHALL NOT accept a new operation in the same cycle a result is consumed; the earliest next acceptance is the edge after the return to IDLE.
REQ-026 The result SHALL equal (a + b + cin) mod 2^(N*W), with cout as bit N*W.

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE with in_ready=1, out_valid=0, busy=0, sum=0, cout=0, idx=0 and carry register 0.
REQ-028 Asserting reset in RUN or DONE SHALL abort the operation immediately with no partial result presented.

Configuration
REQ-029 With macro CLA_SEQ_CTRL_OVF_EN defined, the block SHALL add output port ovf (1 bit), reset to 0 and valid with out_valid, equal to the carry into the MSB XOR cout (two's-complement overflow).
REQ-030 Without CLA_SEQ_CTRL_OVF_EN, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=4, W=4)
REQ-031 Case 1: a=16'hFFFF, b=16'h0001, cin=0 accepted -> out_valid high 4 cycles later, sum=16'h0000, cout=1.
REQ-032 Case 2: a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0; in_ready=0 and busy=1 throughout RUN; in_valid pulsed with other operands during RUN is ignored.
REQ-033 Case 3: result of 16'hA5A5+16'h5A5A, cin=1 held with out_ready=0 for 3 cycles -> sum=16'h0000 and cout=1 held stable, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-034 Case 4: rst_n low in the 2nd RUN cycle -> out_valid=0, sum=0, in_ready=1 immediately; the next operation 16'h0001+16'h0001 -> sum=16'h0002.
REQ-035 Case 5 (CLA_SEQ_CTRL_OVF_EN): 16'h7FFF+16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1; 16'hFFFF+16'hFFFF -> ovf=0, cout=1.
REQ-036 Case 6: 1000 random back-to-back operations with random out_ready stalls -> every sum and cout matches a + b + cin.

Source files
------------

// File: rtl/cla_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cla_seq_ctrl
//
// Sequential adder that reuses a single N-bit carry-lookahead slice over W
// cycles to add two N*W-bit operands plus a carry-in.
//
// Handshake (valid/ready):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. in_ready is high only in IDLE. Operands are captured on the
//   accepting edge, so later input changes have no effect. out_valid rises W
//   edges after the accepting edge. sum/cout hold stable until the edge where
//   out_ready is seen high, after which the block is IDLE again. A new
//   operation cannot be accepted on the same edge a result is consumed.
//
// Optional feature:
//   Define CLA_SEQ_CTRL_OVF_EN to add the ovf output (two's-complement
//   overflow of the full-width add).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a/b/cin valid
//   in_ready   out  block can accept (IDLE only)
//   a, b       in   N*W-bit operands
//   cin        in   carry into bit 0
//   out_valid  out  sum/cout valid
//   out_ready  in   consumer takes the result
//   sum        out  N*W-bit result
//   cout       out  carry out of the MSB
//   busy       out  high in RUN and DONE
//   ovf        out  overflow (only with CLA_SEQ_CTRL_OVF_EN)
//   dbg_state  out  current FSM state (debug)
// -----------------------------------------------------------------------------
module cla_seq_ctrl #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   a,
    input  logic [N*W-1:0]   b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   sum,
    output logic             cout,
    output logic             busy,
`ifdef CLA_SEQ_CTRL_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    localparam int SW = N * W;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [SW-1:0]   r_a;
    logic [SW-1:0]   r_b;
    logic [SW-1:0]   r_sum;
    logic            r_carry;
    logic [IW-1:0]   r_idx;
    logic            r_out_valid;
    logic            r_cout;
`ifdef CLA_SEQ_CTRL_OVF_EN
    logic            r_ovf;
`endif

    logic [N-1:0]    w_sl_a;
    logic [N-1:0]    w_sl_b;
    logic [N-1:0]    w_g;
    logic [N-1:0]    w_p;
    logic [N:0]      w_c;
    logic [N-1:0]    w_sum_sl;
    logic            w_term;
    logic            w_pp;

    assign w_sl_a = r_a[r_idx*N +: N];
    assign w_sl_b = r_b[r_idx*N +: N];

    // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0],
    // each carry computed directly from g/p and the slice carry-in rather
    // than rippled from the previous bit.
    always_comb begin
        w_g      = w_sl_a & w_sl_b;
        w_p      = w_sl_a ^ w_sl_b;
        w_c      = '0;
        w_c[0]   = r_carry;
        w_term   = 1'b0;
        w_pp     = 1'b0;
        for (int i = 0; i < N; i++) begin
            w_term = w_g[i];
            w_pp   = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_term = w_term | (w_pp & w_g[j]);
                w_pp   = w_pp & w_p[j];
            end
            w_c[i+1] = w_term | (w_pp & r_carry);
        end
        w_sum_sl = w_p ^ w_c[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
`ifdef CLA_SEQ_CTRL_OVF_EN
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[r_idx*N +: N] <= w_sum_sl;
                    r_carry             <= w_c[N];
                    if (r_idx == LAST_IDX) begin
                        r_idx       <= '0;
                        r_cout      <= w_c[N];
                        r_out_valid <= 1'b1;
`ifdef CLA_SEQ_CTRL_OVF_EN
                        // Carry into the MSB of the top slice vs carry out.
                        r_ovf       <= w_c[N] ^ w_c[N-1];
`endif
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef CLA_SEQ_CTRL_OVF_EN
    assign ovf       = r_ovf;
`endif
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cla_seq_ctrl
//
// Self-checking bench for cla_seq_ctrl with N=4, W=4 (16-bit operands).
// Expected results come from plain 17-bit arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_cla_seq_ctrl;

  localparam int N  = 4;
  localparam int W  = 4;
  localparam int SW = N * W;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [SW-1:0] a;
  logic [SW-1:0] b;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [SW-1:0] sum;
  logic          cout;
  logic          busy;
  logic          ovf_obs;
  logic [1:0]    dbg_state;

  int checks;
  int errors;

  logic [SW:0] exp_q[$];

  cla_seq_ctrl #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy),
`ifdef CLA_SEQ_CTRL_OVF_EN
    .ovf       (ovf_obs),
`endif
    .dbg_state (dbg_state)
  );

`ifndef CLA_SEQ_CTRL_OVF_EN
  assign ovf_obs = 1'b0;
`endif

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: full-width add, carry out in bit SW
  function automatic logic [SW:0] model_add(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{SW{1'b0}}, c};
  endfunction

  // two's-complement overflow: operands share a sign that the result lacks
  function automatic logic model_ovf(input logic [SW-1:0] x, input logic [SW-1:0] y, input logic c);
    logic [SW:0] r;
    r = model_add(x, y, c);
    return (x[SW-1] == y[SW-1]) && (r[SW-1] != x[SW-1]);
  endfunction

  // driver: one full transaction, returning observations for the caller to check
  task automatic drive_op(input logic [SW-1:0] op_a, input logic [SW-1:0] op_b, input logic op_cin,
                          input int stall,
                          output logic [SW-1:0] got_s, output logic got_c, output logic got_o,
                          output int lat, output bit run_ok, output bit hold_ok, output bit idle_ok);
    int t;
    run_ok  = 1'b1;
    hold_ok = 1'b1;
    idle_ok = 1'b1;
    lat     = 0;
    t       = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    a        = op_a;
    b        = op_b;
    cin      = op_cin;
    in_valid = 1'b1;
    @(posedge clk); #1;
    // operands now latched; inputs and out_ready get noise that must be ignored
    while (out_valid !== 1'b1 && lat < 4 * W + 8) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) run_ok = 1'b0;
      in_valid  = 1'($urandom_range(0, 1));
      a         = SW'($urandom);
      b         = SW'($urandom);
      cin       = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    got_s     = sum;
    got_c     = cout;
    got_o     = ovf_obs;
    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      a        = SW'($urandom);
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || sum !== got_s || cout !== got_c || ovf_obs !== got_o ||
          in_ready !== 1'b0 || busy !== 1'b1) hold_ok = 1'b0;
    end
    // in_valid high on the consuming edge must not start a new operation
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
        sum !== got_s || cout !== got_c) idle_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (sum !== '0 || cout !== 1'b0) begin errors++; $display("FAIL reset_sum: got %h/%b expected 0000/0", sum, cout); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_carry_chain();
    logic [SW-1:0] s; logic c, o; int lat; bit r_ok, h_ok, i_ok;
    drive_op(16'hFFFF, 16'h0001, 1'b0, 0, s, c, o, lat, r_ok, h_ok, i_ok);
    checks++;
    if (lat !== W) begin errors++; $display("FAIL case1_latency: got %0d expected %0d", lat, W); end
    checks++;
    if (s !== 16'h0000 || c !== 1'b1) begin errors++; $display("FAIL case1_result: got %h/%b expected 0000/1", s, c); end
    checks++;
    if (!i_ok) begin errors++; $display("FAIL case1_return_idle: got 0 expected 1"); end
  endtask

  task automatic test_run_ignores_input();
    logic [SW-1:0] s; logic c, o; int lat; bit r_ok, h_ok, i_ok;
    drive_op(16'h1234, 16'h4321, 1'b1, 1, s, c, o, lat, r_ok, h_ok, i_ok);
    checks++;
    if (s !== 16'h5556 || c !== 1'b0) begin errors++; $display("FAIL case2_result: got %h/%b expected 5556/0", s, c); end
    checks++;
    if (!r_ok) begin errors++; $display("FAIL case2_busy_in_ready_in_run: got 0 expected 1"); end
    checks++;
    if (lat !== W) begin errors++; $display("FAIL case2_latency: got %0d expected %0d", lat, W); end
  endtask

  task automatic test_hold();
    logic [SW-1:0] s; logic c, o; int lat; bit r_ok, h_ok, i_ok;
    drive_op(16'hA5A5, 16'h5A5A, 1'b1, 3, s, c, o, lat, r_ok, h_ok, i_ok);
    checks++;
    if (s !== 16'h0000 || c !== 1'b1) begin errors++; $display("FAIL case3_result: got %h/%b expected 0000/1", s, c); end
    checks++;
    if (!h_ok) begin errors++; $display("FAIL case3_hold_stable: got 0 expected 1"); end
    checks++;
    if (!i_ok) begin errors++; $display("FAIL case3_release_idle: got 0 expected 1"); end
  endtask

  task automatic test_reset_abort();
    logic [SW-1:0] s; logic c, o; int lat; bit r_ok, h_ok, i_ok;
    a        = 16'h00FF;
    b        = 16'h0F0F;
    cin      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL case4_abort_flags: got valid=%b ready=%b busy=%b expected 0/1/0", out_valid, in_ready, busy);
    end
    checks++;
    if (sum !== '0 || cout !== 1'b0) begin errors++; $display("FAIL case4_abort_sum: got %h/%b expected 0000/0", sum, cout); end
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(16'h0001, 16'h0001, 1'b0, 0, s, c, o, lat, r_ok, h_ok, i_ok);
    checks++;
    if (s !== 16'h0002 || c !== 1'b0) begin errors++; $display("FAIL case4_next_op: got %h/%b expected 0002/0", s, c); end
  endtask

`ifdef CLA_SEQ_CTRL_OVF_EN
  task automatic test_ovf();
    logic [SW-1:0] s; logic c, o; int lat; bit r_ok, h_ok, i_ok;
    checks++;
    if (ovf_obs !== 1'b0) begin errors++; $display("FAIL case5_ovf_idle: got %b expected 0", ovf_obs); end
    drive_op(16'h7FFF, 16'h0001, 1'b0, 0, s, c, o, lat, r_ok, h_ok, i_ok);
    checks++;
    if (s !== 16'h8000 || c !== 1'b0 || o !== 1'b1) begin
      errors++; $display("FAIL case5_ovf_pos: got %h/%b/%b expected 8000/0/1", s, c, o);
    end
    drive_op(16'hFFFF, 16'hFFFF, 1'b0, 0, s, c, o, lat, r_ok, h_ok, i_ok);
    checks++;
    if (s !== 16'hFFFE || c !== 1'b1 || o !== 1'b0) begin
      errors++; $display("FAIL case5_ovf_neg: got %h/%b/%b expected fffe/1/0", s, c, o);
    end
  endtask
`endif

  task automatic test_back_to_back();
    logic [SW-1:0] s; logic c, o; int lat; bit r_ok, h_ok, i_ok;
    logic [SW-1:0] ra, rb; logic rc; logic [SW:0] exp; logic exp_o;
    for (int n = 0; n < 1000; n++) begin
      ra = SW'($urandom);
      rb = SW'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (n % 10 == 0) ra = '1;
      exp_q.push_back(model_add(ra, rb, rc));
      exp_o = model_ovf(ra, rb, rc);
      drive_op(ra, rb, rc, $urandom_range(0, 3), s, c, o, lat, r_ok, h_ok, i_ok);
      exp = exp_q.pop_front();
      checks++;
      if ({c, s} !== exp) begin
        errors++; $display("FAIL rand_result[%0d]: %h+%h+%b got %b/%h expected %b/%h", n, ra, rb, rc, c, s, exp[SW], exp[SW-1:0]);
      end
`ifdef CLA_SEQ_CTRL_OVF_EN
      checks++;
      if (o !== exp_o) begin errors++; $display("FAIL rand_ovf[%0d]: got %b expected %b", n, o, exp_o); end
`endif
      checks++;
      if (lat !== W || !r_ok || !h_ok || !i_ok) begin
        errors++; $display("FAIL rand_protocol[%0d]: got lat=%0d run=%b hold=%b idle=%b expected %0d/1/1/1", n, lat, r_ok, h_ok, i_ok, W);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_carry_chain();
    test_run_ignores_input();
    test_hold();
    test_reset_abort();
`ifdef CLA_SEQ_CTRL_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
